// File: rtl/ram_clear_dp.sv
// Simple-dual-port RAM with a built-in clear sweep to INIT after reset or on clr.
// Optional macro RAM_REG_OUT_EN registers dout (1-cycle read latency, read-before-write).
module ram_clear_dp #(
   parameter int unsigned   A    = 4,
   parameter int unsigned   D    = 4,
   parameter logic [D-1:0]  INIT = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         we,
   input  logic [A-1:0] waddr,
   input  logic [D-1:0] din,
   input  logic [A-1:0] raddr,
   output logic [D-1:0] dout,
   output logic         busy
);

   localparam int unsigned  DEPTH = 1 << A;
   localparam logic [A-1:0] LAST  = A'(DEPTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } state_t;

   state_t         r_state;
   state_t         w_next_state;
   logic [A-1:0]   r_cnt;
   logic [A-1:0]   w_next_cnt;
   logic           w_mem_we;
   logic [A-1:0]   w_mem_addr;
   logic [D-1:0]   w_mem_data;
   logic [D-1:0]   r_mem [DEPTH];
   logic [D-1:0]   w_rd_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= SWEEP;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
      end
   end

   // Sweep writes INIT at cnt; in IDLE a clr request takes priority over a user write.
   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      w_mem_we     = 1'b0;
      w_mem_addr   = waddr;
      w_mem_data   = din;
      case (r_state)
         IDLE: begin
            if (clr) begin
               w_next_state = SWEEP;
               w_next_cnt   = '0;
            end else if (we) begin
               w_mem_we = 1'b1;
            end
         end
         SWEEP: begin
            w_mem_we   = 1'b1;
            w_mem_addr = r_cnt;
            w_mem_data = INIT;
            w_next_cnt = r_cnt + A'(1);
            if (r_cnt == LAST) begin
               w_next_state = IDLE;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // Storage has no reset; the reset edge itself never writes.
   always_ff @(posedge clk) begin
      if (w_mem_we && !reset) begin
         r_mem[w_mem_addr] <= w_mem_data;
      end
   end

   assign busy      = (r_state == SWEEP);
   assign w_rd_data = busy ? INIT : r_mem[raddr];

`ifdef RAM_REG_OUT_EN
   logic [D-1:0] r_dout;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_dout <= INIT;
      end else begin
         r_dout <= w_rd_data;
      end
   end

   assign dout = r_dout;
`else
   assign dout = w_rd_data;
`endif

endmodule

// File: tb/tb_ram_clear_dp.sv
// Scoreboard bench for ram_clear_dp (A=4, D=4, INIT=4'hA), combinational read build.
module tb_ram_clear_dp;

   logic       clk = 1'b0;
   logic       reset;
   logic       clr;
   logic       we;
   logic [3:0] waddr;
   logic [3:0] din;
   logic [3:0] raddr;
   logic [3:0] dout;
   logic       busy;

   int cyc    = 0;
   int n_chk  = 0;
   int n_pass = 0;

   int         q_cyc  [$];
   logic       q_busy [$];
   logic [3:0] q_dout [$];
   string      q_name [$];

   ram_clear_dp #(.A(4), .D(4), .INIT(4'hA)) dut (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .we    (we),
      .waddr (waddr),
      .din   (din),
      .raddr (raddr),
      .dout  (dout),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every expectation tagged for the current cycle at mid-cycle.
   always @(negedge clk) begin
      while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
         int         c;
         logic       eb;
         logic [3:0] ed;
         string      nm;
         c  = q_cyc.pop_front();
         eb = q_busy.pop_front();
         ed = q_dout.pop_front();
         nm = q_name.pop_front();
         n_chk = n_chk + 1;
         if (c != cyc) begin
            $display("FAIL %s: stale expectation for cycle %0d seen at cycle %0d", nm, c, cyc);
         end else if (busy !== eb || dout !== ed) begin
            $display("FAIL %s: got busy=%0b dout=%h, expected busy=%0b dout=%h",
                     nm, busy, dout, eb, ed);
         end else begin
            n_pass = n_pass + 1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_now(input string nm, input logic eb, input logic [3:0] ed);
      q_cyc.push_back(cyc);
      q_busy.push_back(eb);
      q_dout.push_back(ed);
      q_name.push_back(nm);
   endtask

   // 16 busy cycles reading INIT, optional write pulse at interval wr_at, then idle.
   task automatic sweep_check(input string nm, input int wr_at);
      for (int i = 0; i < 16; i++) begin
         if (i == wr_at) begin
            we = 1'b1; waddr = 4'd9; din = 4'h1; raddr = 4'd9;
         end else begin
            we = 1'b0;
         end
         expect_now(nm, 1'b1, 4'hA);
         step();
      end
      we = 1'b0;
      expect_now({nm, "_end"}, 1'b0, 4'hA);
   endtask

   task automatic read_check(input string nm, input logic [3:0] a, input logic [3:0] ed);
      raddr = a;
      expect_now(nm, 1'b0, ed);
      step();
   endtask

   initial begin
      reset = 1'b1; clr = 1'b0; we = 1'b0; waddr = '0; din = '0; raddr = '0;
      step();
      // Reset held for three edges
      for (int i = 0; i < 2; i++) begin
         expect_now("reset_hold", 1'b1, 4'hA);
         step();
      end
      reset = 1'b0;
      sweep_check("reset_sweep", -1);
      step();
      for (int i = 0; i < 16; i++) read_check("init_read", 4'(i), 4'hA);

      // Same-address write/read
      we = 1'b1; waddr = 4'd5; din = 4'h3; raddr = 4'd5;
      expect_now("wr_before", 1'b0, 4'hA);
      step();
      we = 1'b0;
      expect_now("wr_after", 1'b0, 4'h3);
      step();

      // clr beats we; write during busy ignored
      we = 1'b1; waddr = 4'd2; din = 4'h7; clr = 1'b1; raddr = 4'd2;
      expect_now("clr_edge", 1'b0, 4'hA);
      step();
      we = 1'b0; clr = 1'b0;
      sweep_check("clr_sweep", 5);
      raddr = 4'd9;
      step();
      read_check("clr_addr2", 4'd2, 4'hA);
      read_check("busy_wr_addr9", 4'd9, 4'hA);
      read_check("clr_addr5", 4'd5, 4'hA);

      // Reset when cnt=10 restarts the sweep
      clr = 1'b1;
      step();
      clr = 1'b0;
      for (int i = 0; i < 10; i++) begin
         expect_now("pre_reset_sweep", 1'b1, 4'hA);
         step();
      end
      reset = 1'b1;
      expect_now("mid_reset", 1'b1, 4'hA);
      step();
      reset = 1'b0;
      sweep_check("restart_sweep", -1);
      step();

      // Boundary addresses
      we = 1'b1; waddr = 4'd15; din = 4'hF;
      step();
      waddr = 4'd0; din = 4'h0;
      step();
      we = 1'b0;
      read_check("addr15", 4'd15, 4'hF);
      read_check("addr0", 4'd0, 4'h0);
      clr = 1'b1;
      step();
      clr = 1'b0;
      sweep_check("wrap_sweep", -1);
      step();
      read_check("addr15_clr", 4'd15, 4'hA);
      read_check("addr0_clr", 4'd0, 4'hA);

      repeat (2) @(negedge clk);
      #1;
      if (q_cyc.size() != 0) begin
         n_chk = n_chk + 1;
         $display("FAIL drain: %0d expectations left, required 0", q_cyc.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
